// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter sharing the regfile write port between the ALU (req0) and load unit (req1).
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write onto the read data outputs.
module regfile_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  logic                  prio_q, prio_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  gnt0, gnt1;

  // prio_q = 0 favours requester 0 when both are valid
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !hold) begin
      gnt0 = req0_valid && (!req1_valid || !prio_q);
      gnt1 = req1_valid && (!req0_valid ||  prio_q);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Writes to r0 are accepted but leave wr_en low
  always_comb begin
    prio_d    = prio_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt0) begin
      prio_d    = 1'b1;
      wr_addr_d = req0_addr;
      wr_data_d = req0_data;
      wr_en_d   = (req0_addr != '0);
    end else if (gnt1) begin
      prio_d    = 1'b0;
      wr_addr_d = req1_addr;
      wr_data_d = req1_data;
      wr_en_d   = (req1_addr != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data1 = rf_rd_data1;
    rd_data2 = rf_rd_data2;
    if (wr_en_q && (rd_addr1 == wr_addr_q) && (rd_addr1 != '0)) rd_data1 = wr_data_q;
    if (wr_en_q && (rd_addr2 == wr_addr_q) && (rd_addr2 != '0)) rd_data2 = wr_data_q;
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign rd_data1 = rf_rd_data1;
  assign rd_data2 = rf_rd_data2;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed vector bench for regfile_wr_arb: grant/ready, registered write port and read bypass.
module tb_regfile_wr_arb;

  logic       clk = 1'b0;
  logic       rst, hold;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_addr, req1_addr, wr_addr, rd_addr1, rd_addr2;
  logic [7:0] req0_data, req1_data, wr_data, rf_rd_data1, rf_rd_data2, rd_data1, rd_data2;
  logic       wr_en;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  regfile_wr_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  typedef struct {
    logic       rst, hold;
    logic       v0;
    logic [5:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [5:0] a1;
    logic [7:0] d1;
    logic       r0, r1;   // expected ready this cycle
    logic       en;       // expected write port after the next edge
    logic [5:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic r, logic h, logic v0, logic [5:0] a0, logic [7:0] d0,
                              logic v1, logic [5:0] a1, logic [7:0] d1,
                              logic r0, logic r1, logic en, logic [5:0] wa, logic [7:0] wd);
    vec_t v;
    v.rst = r; v.hold = h; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.en = en; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //            rst h  v0 a0  d0     v1 a1  d1     r0 r1 en wa  wd
    vecs[0]  = mk(1, 0, 1, 1,  8'h11, 1, 2,  8'h22, 0, 0, 0, 0,  8'h00);
    vecs[1]  = mk(1, 0, 1, 1,  8'h11, 1, 2,  8'h22, 0, 0, 0, 0,  8'h00);
    vecs[2]  = mk(0, 0, 1, 1,  8'h11, 1, 2,  8'h22, 1, 0, 1, 1,  8'h11);
    vecs[3]  = mk(0, 0, 1, 1,  8'h11, 1, 2,  8'h22, 0, 1, 1, 2,  8'h22);
    vecs[4]  = mk(0, 0, 1, 1,  8'h11, 1, 2,  8'h22, 1, 0, 1, 1,  8'h11);
    vecs[5]  = mk(0, 0, 1, 1,  8'h11, 1, 2,  8'h22, 0, 1, 1, 2,  8'h22);
    vecs[6]  = mk(0, 0, 1, 5,  8'hA5, 0, 0,  8'h00, 1, 0, 1, 5,  8'hA5);
    vecs[7]  = mk(0, 0, 0, 0,  8'h00, 1, 0,  8'hFF, 0, 1, 0, 0,  8'hFF);
    vecs[8]  = mk(0, 0, 1, 3,  8'h33, 1, 4,  8'h44, 1, 0, 1, 3,  8'h33);
    vecs[9]  = mk(0, 0, 0, 0,  8'h00, 1, 4,  8'h44, 0, 1, 1, 4,  8'h44);
    vecs[10] = mk(0, 0, 0, 0,  8'h00, 1, 6,  8'h66, 0, 1, 1, 6,  8'h66);
    vecs[11] = mk(0, 0, 1, 3,  8'h33, 1, 4,  8'h44, 1, 0, 1, 3,  8'h33);
    vecs[12] = mk(0, 1, 1, 9,  8'h99, 0, 0,  8'h00, 0, 0, 0, 3,  8'h33);
    vecs[13] = mk(0, 1, 1, 9,  8'h99, 0, 0,  8'h00, 0, 0, 0, 3,  8'h33);
    vecs[14] = mk(0, 1, 1, 9,  8'h99, 0, 0,  8'h00, 0, 0, 0, 3,  8'h33);
    vecs[15] = mk(0, 0, 1, 9,  8'h99, 0, 0,  8'h00, 1, 0, 1, 9,  8'h99);
    vecs[16] = mk(0, 0, 0, 0,  8'h00, 0, 0,  8'h00, 0, 0, 0, 9,  8'h99);
    vecs[17] = mk(0, 0, 1, 8,  8'h88, 0, 0,  8'h00, 1, 0, 1, 8,  8'h88);
    vecs[18] = mk(1, 0, 1, 8,  8'h88, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00);
    vecs[19] = mk(0, 0, 1, 1,  8'h11, 1, 2,  8'h22, 1, 0, 1, 1,  8'h11);
    vecs[20] = mk(0, 0, 1, 10, 8'hA1, 1, 10, 8'hB2, 0, 1, 1, 10, 8'hB2);
    vecs[21] = mk(0, 0, 1, 10, 8'hA1, 0, 0,  8'h00, 1, 0, 1, 10, 8'hA1);

    rd_addr1 = '0; rd_addr2 = '0; rf_rd_data1 = 8'h00; rf_rd_data2 = 8'h00;

    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; hold = vecs[i].hold;
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
      #1;
      chk($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      chk($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      @(posedge clk); #1;
      chk($sformatf("v%0d wr_en", i),   32'(wr_en),   32'(vecs[i].en));
      chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].wa));
      chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].wd));
    end

    // Read path: write r7=0x3C, then read it while wr_en is high
    hold = 1'b0; rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 6'd7; req0_data = 8'h3C; req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("byp wr_en", 32'(wr_en), 32'd1);
    rd_addr1 = 6'd7; rf_rd_data1 = 8'h00; rd_addr2 = 6'd0; rf_rd_data2 = 8'h5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp rd_data1 hit", 32'(rd_data1), 32'h3C);
`else
    chk("byp rd_data1 hit", 32'(rd_data1), 32'h00);
`endif
    chk("byp rd_data2 r0", 32'(rd_data2), 32'h5A);
    rd_addr2 = 6'd7; rf_rd_data2 = 8'h21;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp rd_data2 hit", 32'(rd_data2), 32'h3C);
`else
    chk("byp rd_data2 hit", 32'(rd_data2), 32'h21);
`endif
    @(posedge clk); #1;
    rf_rd_data1 = 8'h77; rf_rd_data2 = 8'h66;
    #1;
    chk("byp idle wr_en", 32'(wr_en), 32'd0);
    chk("byp idle rd_data1", 32'(rd_data1), 32'h77);
    chk("byp idle rd_data2", 32'(rd_data2), 32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
